// File: rtl/match_fifo.sv
// Multi-lane hash matcher: compares each lane against a masked target,
// queues the lowest-index hit (or a forced sample) and serialises records on request.
module match_fifo #(
    parameter int LANES    = 4,
    parameter int WIDTH    = 32,
    parameter int TAG_BITS = 16,
    parameter int DEPTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          lane_valid,
    input  logic [LANES*WIDTH-1:0]    lane_hash,
    input  logic [LANES*TAG_BITS-1:0] lane_tag,
    input  logic                      cfg_we,
    input  logic [WIDTH-1:0]          cfg_target,
    input  logic [$clog2(WIDTH+1)-1:0] cfg_mask_bits,
    input  logic                      sample,
    input  logic                      rd_req,
    output logic                      rd_bit,
    output logic                      busy,
    output logic                      empty,
    output logic [15:0]               drop_count
);

    localparam int LB    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int REC_W = 1 + LB + TAG_BITS + WIDTH;
    localparam int MB    = $clog2(WIDTH + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(REC_W);
    localparam int NW    = $clog2(LANES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    // Top-n-bits mask; counts beyond WIDTH saturate to a full mask.
    function automatic logic [WIDTH-1:0] mask_of(input logic [MB-1:0] n);
        logic [MB-1:0] c;
        c = (n > MB'(WIDTH)) ? MB'(WIDTH) : n;
        return ~({WIDTH{1'b1}} >> c);
    endfunction

    logic [WIDTH-1:0]          target;
    logic [WIDTH-1:0]          mask;
    logic [LANES-1:0]          hit_c;
    logic [LANES-1:0]          s1_hit;
    logic [LANES*WIDTH-1:0]    s1_hash;
    logic [LANES*TAG_BITS-1:0] s1_tag;
    logic                      s1_sample;

    logic [LB-1:0]    win;
    logic             found;
    logic [NW-1:0]    nhits;
    logic             wr_req;
    logic             wr_ok;
    logic             pop;
    logic             full;
    logic [REC_W-1:0] rec;
    logic [16:0]      lost;
    logic [16:0]      drop_sum;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    state_t           state;
    logic [REC_W-1:0] pop_rec;
    logic [REC_W-1:0] shreg;
    logic [CW-1:0]    cnt;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = (state == IDLE) && rd_req && !empty && !busy;
    assign wr_ok = wr_req && (!full || pop);

    // Match target and mask, loaded from the config port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
            mask   <= '1;
        end else if (cfg_we) begin
            target <= cfg_target;
            mask   <= mask_of(cfg_mask_bits);
        end
    end

    // Per-lane masked compare against the current target.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_c[i] = lane_valid[i] &&
                (((lane_hash[i*WIDTH +: WIDTH] ^ target) & mask) == '0);
        end
    end

    // Stage 1: register hits with their hash, tag and sample request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hit    <= '0;
            s1_hash   <= '0;
            s1_tag    <= '0;
            s1_sample <= 1'b0;
        end else begin
            s1_hit    <= hit_c;
            s1_hash   <= lane_hash;
            s1_tag    <= lane_tag;
            s1_sample <= sample;
        end
    end

    // Stage 2: priority pick, record assembly and loss accounting.
    always_comb begin
        win   = '0;
        found = 1'b0;
        nhits = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_hit[i]) begin
                nhits = nhits + NW'(1);
                if (!found) begin
                    win   = LB'(i);
                    found = 1'b1;
                end
            end
        end
        wr_req = found || s1_sample;
        rec = {s1_sample, win,
               s1_tag[int'(win)*TAG_BITS +: TAG_BITS],
               s1_hash[int'(win)*WIDTH +: WIDTH]};
        lost = '0;
        if (found) lost = 17'(nhits) - 17'd1;
        if (wr_req && !wr_ok) lost = lost + 17'd1;
        drop_sum = {1'b0, drop_count} + lost;
    end

    // Write pointer and saturating loss counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            drop_count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Record storage; no reset needed, validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr[AW-1:0]] <= rec;
    end

    // Readout FSM: pop, load shifter, then shift out LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rptr    <= '0;
            pop_rec <= '0;
            shreg   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            rd_bit  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        pop_rec <= mem[rptr[AW-1:0]];
                        rptr    <= rptr + 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    shreg  <= pop_rec;
                    rd_bit <= pop_rec[0];
                    busy   <= 1'b1;
                    cnt    <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == CW'(REC_W - 1)) begin
                        busy   <= 1'b0;
                        rd_bit <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        shreg  <= shreg >> 1;
                        rd_bit <= shreg[1];
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_fifo.sv
// Self-checking bench for match_fifo: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_match_fifo;

    localparam int LANES    = 4;
    localparam int WIDTH    = 32;
    localparam int TAG_BITS = 16;
    localparam int DEPTH    = 16;
    localparam int LB       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int REC_W    = 1 + LB + TAG_BITS + WIDTH;
    localparam int MB       = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] TGT = 32'h98BADCFF;

    logic                      clk;
    logic                      rst;
    logic [LANES-1:0]          lane_valid;
    logic [LANES*WIDTH-1:0]    lane_hash;
    logic [LANES*TAG_BITS-1:0] lane_tag;
    logic                      cfg_we;
    logic [WIDTH-1:0]          cfg_target;
    logic [MB-1:0]             cfg_mask_bits;
    logic                      sample;
    logic                      rd_req;
    logic                      rd_bit;
    logic                      busy;
    logic                      empty;
    logic [15:0]               drop_count;

    int errors = 0;
    int checks = 0;

    logic [REC_W-1:0] mq[$];
    int unsigned      mdrop;
    logic [WIDTH-1:0] mtgt;
    int               mmb;

    match_fifo #(
        .LANES(LANES), .WIDTH(WIDTH), .TAG_BITS(TAG_BITS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_hash(lane_hash),
        .lane_tag(lane_tag), .cfg_we(cfg_we), .cfg_target(cfg_target),
        .cfg_mask_bits(cfg_mask_bits), .sample(sample), .rd_req(rd_req),
        .rd_bit(rd_bit), .busy(busy), .empty(empty), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_hit(input logic [WIDTH-1:0] h);
        if (mmb == 0) return 1'b1;
        return (h >> (WIDTH - mmb)) == (mtgt >> (WIDTH - mmb));
    endfunction

    task automatic m_apply(input logic [LANES-1:0] v,
                           input logic [LANES*WIDTH-1:0] h,
                           input logic [LANES*TAG_BITS-1:0] t,
                           input logic s);
        int n = 0;
        int w = -1;
        int lost = 0;
        logic [LB-1:0] wi;
        for (int i = 0; i < LANES; i++) begin
            if (v[i] && m_hit(h[i*WIDTH +: WIDTH])) begin
                n++;
                if (w < 0) w = i;
            end
        end
        if (n > 0 || s) begin
            if (w < 0) w = 0;
            wi = LB'(w);
            if (mq.size() < DEPTH) begin
                mq.push_back({s, wi, t[w*TAG_BITS +: TAG_BITS], h[w*WIDTH +: WIDTH]});
                lost = (n > 0) ? n - 1 : 0;
            end else begin
                lost = (n > 0) ? n : 1;
            end
        end
        mdrop = mdrop + lost;
        if (mdrop > 65535) mdrop = 65535;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mdrop = 0;
        mtgt  = '0;
        mmb   = WIDTH;
    endtask

    task automatic set_cfg(input logic [WIDTH-1:0] tg, input int mb);
        cfg_we = 1'b1;
        cfg_target = tg;
        cfg_mask_bits = MB'(mb);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        mtgt = tg;
        mmb  = (mb > WIDTH) ? WIDTH : mb;
    endtask

    task automatic drive(input logic [LANES-1:0] v,
                         input logic [LANES*WIDTH-1:0] h,
                         input logic [LANES*TAG_BITS-1:0] t,
                         input logic s);
        lane_valid = v;
        lane_hash  = h;
        lane_tag   = t;
        sample     = s;
        m_apply(v, h, t, s);
        @(posedge clk);
        #1;
        lane_valid = '0;
        sample     = 1'b0;
    endtask

    task automatic read_record(output logic [REC_W-1:0] rec, output bit ok);
        ok  = 1'b1;
        rec = '0;
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        if (busy !== 1'b0) ok = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < REC_W; k++) begin
            if (busy !== 1'b1) ok = 1'b0;
            rec[k] = rd_bit;
            @(posedge clk);
            #1;
        end
        if (busy !== 1'b0 || rd_bit !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] exp;
        bit ok;
        rst = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || busy !== 1'b0 || rd_bit !== 1'b0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: empty=%b busy=%b rd_bit=%b drop=%h want 1 0 0 0000",
                     empty, busy, rd_bit, drop_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mdrop = 0;
        mtgt  = '0;
        mmb   = WIDTH;
        drive(4'b0100, '0, {16'hD, 16'hC, 16'hB, 16'hA}, 1'b0);
        idle(1);
        exp = mq.pop_front();
        read_record(got, ok);
        checks++;
        if (got !== exp || !ok) begin
            errors++;
            $display("FAIL reset_cfg_default: got %h ok=%0d want %h", got, ok, exp);
        end
    endtask

    task automatic test_exact_match();
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] exp;
        bit ok;
        do_reset();
        set_cfg(TGT, 32);
        drive(4'b0100, {32'h0, TGT, 32'h1, 32'h2}, {16'h0, 16'h1234, 16'h0, 16'h0}, 1'b0);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL latency_early: empty=%b want 1", empty);
        end
        idle(1);
        checks++;
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL latency_write: empty=%b want 0", empty);
        end
        exp = {1'b0, 2'd2, 16'h1234, TGT};
        read_record(got, ok);
        checks++;
        if (got !== exp || !ok) begin
            errors++;
            $display("FAIL exact_record: got %h ok=%0d want %h", got, ok, exp);
        end
    endtask

    task automatic test_multi_hit();
        logic [REC_W-1:0] got;
        bit ok;
        do_reset();
        set_cfg(TGT, 8);
        drive(4'b1010, {32'h98000000, 32'h0, 32'h98000000, 32'h0},
              {16'h3333, 16'h2222, 16'h1111, 16'h0}, 1'b0);
        idle(2);
        checks++;
        if (drop_count !== 16'd1) begin
            errors++;
            $display("FAIL multi_drop: got %0d want 1", drop_count);
        end
        read_record(got, ok);
        checks++;
        if (got !== {1'b0, 2'd1, 16'h1111, 32'h98000000} || !ok) begin
            errors++;
            $display("FAIL multi_record: got %h ok=%0d want lane 1 record", got, ok);
        end
    endtask

    task automatic test_fill_order();
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] exp;
        bit ok;
        logic [LANES*WIDTH-1:0] h;
        int bad;
        do_reset();
        set_cfg(TGT, 32);
        h = {LANES{TGT}};
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(LANES'(1) << (i % LANES), h, {LANES{16'(i + 16'h100)}}, 1'b0);
        end
        idle(2);
        checks++;
        if (drop_count !== 16'd2) begin
            errors++;
            $display("FAIL fill_drop: got %0d want 2", drop_count);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp = mq.pop_front();
            read_record(got, ok);
            if (got !== exp || !ok) bad++;
        end
        checks++;
        if (bad != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL fill_order: bad=%0d empty=%b want 0 1", bad, empty);
        end
    endtask

    task automatic test_sample();
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] exp;
        bit ok;
        do_reset();
        set_cfg(TGT, 32);
        drive(4'b0000, {32'h4, 32'h3, 32'h2, 32'h11223344},
              {16'h0, 16'h0, 16'h0, 16'h5A5A}, 1'b1);
        idle(1);
        exp = mq.pop_front();
        read_record(got, ok);
        checks++;
        if (got !== exp || got[REC_W-1] !== 1'b1 || got[REC_W-2 -: LB] !== '0) begin
            errors++;
            $display("FAIL sample_record: got %h want %h", got, exp);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sample_busy: busy window wrong, want %0d cycles", REC_W);
        end
        drive(4'b1000, {TGT, 32'h0, 32'h0, 32'h0}, {16'h77, 16'h0, 16'h0, 16'h0}, 1'b1);
        idle(1);
        exp = mq.pop_front();
        read_record(got, ok);
        checks++;
        if (got !== exp || !ok) begin
            errors++;
            $display("FAIL sample_with_hit: got %h want %h", got, exp);
        end
    endtask

    task automatic test_full_pop();
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] exp;
        bit ok;
        int bad;
        do_reset();
        set_cfg(TGT, 32);
        for (int i = 0; i < DEPTH; i++) begin
            drive(4'b0001, {LANES{TGT}}, {LANES{16'(i)}}, 1'b0);
        end
        idle(2);
        exp = mq.pop_front();
        drive(4'b0010, {LANES{TGT}}, {LANES{16'hBEEF}}, 1'b0);
        read_record(got, ok);
        checks++;
        if (got !== exp || !ok) begin
            errors++;
            $display("FAIL fullpop_record: got %h want %h", got, exp);
        end
        checks++;
        if (drop_count !== 16'(mdrop)) begin
            errors++;
            $display("FAIL fullpop_drop: got %0d want %0d", drop_count, mdrop);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (empty !== 1'b0) bad++;
            exp = mq.pop_front();
            read_record(got, ok);
            if (got !== exp || !ok) bad++;
        end
        checks++;
        if (bad != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_occupancy: bad=%0d empty=%b want 0 1", bad, empty);
        end
    endtask

    task automatic test_random();
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] exp;
        bit ok;
        logic [LANES-1:0] v;
        logic [LANES*WIDTH-1:0] h;
        logic [LANES*TAG_BITS-1:0] t;
        logic [WIDTH-1:0] tg;
        int bad;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            tg = $urandom();
            set_cfg(tg, $urandom_range(0, 40));
            for (int c = 0; c < 20; c++) begin
                v = LANES'($urandom());
                for (int i = 0; i < LANES; i++) begin
                    if ($urandom_range(0, 1) == 1)
                        h[i*WIDTH +: WIDTH] = tg ^ ($urandom() >> $urandom_range(4, 31));
                    else
                        h[i*WIDTH +: WIDTH] = $urandom();
                    t[i*TAG_BITS +: TAG_BITS] = TAG_BITS'($urandom());
                end
                drive(v, h, t, ($urandom_range(0, 9) == 0));
            end
            idle(2);
            checks++;
            if (drop_count !== 16'(mdrop)) begin
                errors++;
                $display("FAIL random_drop round %0d: got %0d want %0d", r, drop_count, mdrop);
            end
            bad = 0;
            while (mq.size() > 0) begin
                exp = mq.pop_front();
                read_record(got, ok);
                if (got !== exp || !ok) bad++;
            end
            checks++;
            if (bad != 0 || empty !== 1'b1) begin
                errors++;
                $display("FAIL random_records round %0d: bad=%0d empty=%b", r, bad, empty);
            end
        end
    endtask

    task automatic test_saturate_and_abort();
        do_reset();
        set_cfg(TGT, 0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(4'b0001, {LANES{32'h1}}, {LANES{16'(i)}}, 1'b0);
        end
        lane_valid = '1;
        lane_hash  = {LANES{32'h5}};
        for (int c = 0; c < 16383; c++) begin
            m_apply(lane_valid, lane_hash, lane_tag, 1'b0);
            @(posedge clk);
        end
        #1;
        lane_valid = '0;
        idle(2);
        checks++;
        if (drop_count !== 16'(mdrop)) begin
            errors++;
            $display("FAIL near_sat: got %0d want %0d", drop_count, mdrop);
        end
        drive(4'b1111, {LANES{32'h5}}, '0, 1'b0);
        drive(4'b1111, {LANES{32'h5}}, '0, 1'b0);
        idle(2);
        checks++;
        if (drop_count !== 16'hFFFF || mdrop != 65535) begin
            errors++;
            $display("FAIL saturate: got %h want ffff", drop_count);
        end
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        idle(6);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: busy=%b want 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_bit !== 1'b0 || empty !== 1'b1 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b rd_bit=%b empty=%b drop=%h want 0 0 1 0",
                     busy, rd_bit, empty, drop_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        lane_valid = '0;
        lane_hash = '0;
        lane_tag = '0;
        cfg_we = 1'b0;
        cfg_target = '0;
        cfg_mask_bits = '0;
        sample = 1'b0;
        rd_req = 1'b0;
        mdrop = 0;
        mtgt = '0;
        mmb = WIDTH;
        #2;
        test_reset();
        test_exact_match();
        test_multi_hit();
        test_fill_order();
        test_sample();
        test_full_pop();
        test_random();
        test_saturate_and_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_fifo.md
MATCH_FIFO -- requirements
Module: match_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LANES, 4, number of hash lanes compared per cycle
- WIDTH, 32, hash word width
- TAG_BITS, 16, per-lane metadata tag width
- DEPTH, 16, result FIFO entries (power of 2, at least 2)
- LB = max(1, clog2(LANES)); REC_W = 1 + LB + TAG_BITS + WIDTH
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- lane_valid  in  LANES  per-lane hash valid
- lane_hash  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
- lane_tag  in  LANES*TAG_BITS  lane i at [i*TAG_BITS +: TAG_BITS]
- cfg_we  in  1  load cfg_target and cfg_mask_bits
- cfg_target  in  WIDTH  match target value
- cfg_mask_bits  in  clog2(WIDTH+1)  number of compared MSBs (0..WIDTH)
- sample  in  1  force-capture request
- rd_req  in  1  pop and serialise one record
- rd_bit  out  1  serial record bit, LSB first
- busy  out  1  serialiser active
- empty  out  1  FIFO empty
- drop_count  out  16  saturating count of lost matches

Function
REQ-003 On cfg_we, target and mask SHALL update at the next clk edge; mask = top cfg_mask_bits bits set; values above WIDTH SHALL be treated as WIDTH.
REQ-004 Stage 1 (edge after inputs): hit[i] SHALL equal lane_valid[i] && ((lane_hash[i] ^ target) & mask) == 0; hash, tag and sample SHALL be registered alongside.
REQ-005 cfg_mask_bits = 0 SHALL make every valid lane hit.
REQ-006 Stage 2: the winner SHALL be the lowest-index lane with a hit; a write SHALL occur when any hit is set or the staged sample is set.
REQ-007 Sample with no hit SHALL write a lane-0 record with sample flag 1, regardless of lane_valid[0].
REQ-008 Sample with a hit SHALL write the winning lane's record with sample flag 1.
REQ-009 Record layout SHALL be {sample_flag, lane_idx[LB], tag, hash}, with hash in the LSBs.
REQ-010 Total latency SHALL be 2 cycles: inputs at edge t, FIFO write at edge t+2, empty low after edge t+2.
REQ-011 Each extra simultaneous hit beyond the winner SHALL add 1 to drop_count.
REQ-012 A write attempted while the FIFO is full SHALL be discarded and SHALL add 1 to drop_count.
REQ-013 If both REQ-011 and REQ-012 apply in one cycle, drop_count SHALL increase by the total number of lost hits.
REQ-014 drop_count SHALL saturate at 16'hFFFF.
REQ-015 The FIFO SHALL hold DEPTH records; pointers SHALL wrap mod DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-016 Readout FSM states:
- IDLE -> LOAD on rd_req && !empty && !busy; the pop happens at this edge.
- LOAD -> SHIFT after one cycle; the popped record is loaded into the shifter and busy goes high.
- SHIFT: rd_bit = current LSB; the shifter shifts right each cycle; SHIFT -> IDLE after REC_W bit-cycles, then busy goes low and rd_bit = 0.
REQ-017 rd_req SHALL be ignored while empty, busy, or in LOAD.
REQ-018 A pop and a write in the same cycle SHALL both succeed, including when full, so occupancy is unchanged.

Reset
REQ-019 While rst is high: FIFO pointers = 0, empty = 1, busy = 0, rd_bit = 0, drop_count = 0, target = 0, mask = all ones (WIDTH bits), stage registers cleared, FSM = IDLE.
REQ-020 rst asserted mid-readout SHALL abort the readout immediately; a pending record SHALL be lost.

Verification
REQ-021 Bench scenarios:
- WIDTH=32, LANES=4, target 0x98BADCFF, mask_bits 32; lane 2 hash 0x98BADCFF, tag 0x1234 -> one record {0, 2, 0x1234, 0x98BADCFF}; empty low 2 cycles after input.
- mask_bits 8; lanes 1 and 3 hash 0x98000000, both valid -> lane-1 record written; drop_count = 1.
- DEPTH+2 single-lane hits with no reads -> DEPTH records stored; drop_count = 2; pop order matches write order.
- sample pulse with no hits -> record with sample flag 1, lane 0; serial readout of REC_W bits matches the record LSB first; busy high exactly REC_W cycles.
- FIFO full, rd_req and a hit in the same cycle -> occupancy stays DEPTH; drop_count unchanged.
- drop_count preset near 0xFFFF by sustained drops, then 4 more drops -> holds 0xFFFF; rst mid-SHIFT -> busy 0, rd_bit 0, empty 1.
